// File: rtl/switch_ingress_arbiter.sv
`default_nettype none
// ============================================================================
// switch_ingress_arbiter
//   Round-robin arbiter that serialises NUM_REQ packet sources MSB-first onto
//   the switch ingress, one packet per switch egress burst.
//   Revision: 1.0
// ============================================================================
module switch_ingress_arbiter #(
   parameter int NUM_REQ     = 4,
   parameter int PKT_W       = 64,
   parameter int TIMEOUT_CYC = 200
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NUM_REQ-1:0]       req_valid,
   input  logic [NUM_REQ*PKT_W-1:0] req_data,
   output logic [NUM_REQ-1:0]       req_ready,
   output logic                     ser_data,
   output logic                     ser_valid,
   input  logic                     sw_valid_out,
   output logic [2:0]               grant_id,
   output logic                     busy,
   output logic                     timeout_err,
   input  logic                     err_clr
);

   localparam int            BW         = $clog2(PKT_W);
   localparam int            TW         = $clog2(TIMEOUT_CYC);
   localparam logic [BW-1:0] C_BIT_LAST = BW'(PKT_W - 1);
   localparam logic [TW-1:0] C_TMO_LAST = TW'(TIMEOUT_CYC - 1);
   localparam logic [2:0]    C_GNT_RST  = 3'(NUM_REQ - 1);

   typedef enum logic [1:0] {
      S_IDLE      = 2'd0,
      S_SEND      = 2'd1,
      S_WAIT_RISE = 2'd2,
      S_WAIT_FALL = 2'd3
   } state_t;

   state_t           state_q, state_d;
   logic [PKT_W-1:0] shreg_q, shreg_d;
   logic [BW-1:0]    bitcnt_q, bitcnt_d;
   logic [TW-1:0]    tmo_q, tmo_d;
   logic [2:0]       grant_q, grant_d;
   logic             err_q, err_d;

   logic             w_any, w_hi_hit, w_tmo_set;
   logic [2:0]       w_lo, w_hi, w_gnt;
   logic [NUM_REQ-1:0] w_ready;
   logic [PKT_W-1:0] w_pkt;

   // Lowest requester above the last grant wins; otherwise wrap to the lowest overall.
   always_comb begin
      w_any    = 1'b0;
      w_hi_hit = 1'b0;
      w_lo     = '0;
      w_hi     = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (req_valid[i]) begin
            w_any = 1'b1;
            w_lo  = 3'(i);
         end
         if (req_valid[i] && (3'(i) > grant_q)) begin
            w_hi_hit = 1'b1;
            w_hi     = 3'(i);
         end
      end
      w_gnt = w_hi_hit ? w_hi : w_lo;
   end

   always_comb begin
      w_pkt   = '0;
      w_ready = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (w_gnt == 3'(i)) begin
            w_pkt      = req_data[i*PKT_W +: PKT_W];
            w_ready[i] = (state_q == S_IDLE) && w_any;
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      shreg_d   = shreg_q;
      bitcnt_d  = bitcnt_q;
      tmo_d     = tmo_q;
      grant_d   = grant_q;
      err_d     = err_q;
      w_tmo_set = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (w_any) begin
               shreg_d  = w_pkt;
               grant_d  = w_gnt;
               bitcnt_d = '0;
               state_d  = S_SEND;
            end
         end
         S_SEND: begin
            shreg_d = {shreg_q[PKT_W-2:0], 1'b0};
            if (bitcnt_q == C_BIT_LAST) begin
               tmo_d   = '0;
               state_d = S_WAIT_RISE;
            end else begin
               bitcnt_d = bitcnt_q + BW'(1);
            end
         end
         S_WAIT_RISE: begin
            if (tmo_q == C_TMO_LAST) begin
               w_tmo_set = 1'b1;
               state_d   = S_IDLE;
            end else begin
               tmo_d = tmo_q + TW'(1);
               if (sw_valid_out) state_d = S_WAIT_FALL;
            end
         end
         S_WAIT_FALL: begin
            // A burst ending on the last allowed cycle still counts as completed.
            if (!sw_valid_out) begin
               state_d = S_IDLE;
            end else if (tmo_q == C_TMO_LAST) begin
               w_tmo_set = 1'b1;
               state_d   = S_IDLE;
            end else begin
               tmo_d = tmo_q + TW'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase
      if (err_clr)        err_d = 1'b0;
      else if (w_tmo_set) err_d = 1'b1;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= S_IDLE;
         shreg_q  <= '0;
         bitcnt_q <= '0;
         tmo_q    <= '0;
         grant_q  <= C_GNT_RST;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         shreg_q  <= shreg_d;
         bitcnt_q <= bitcnt_d;
         tmo_q    <= tmo_d;
         grant_q  <= grant_d;
         err_q    <= err_d;
      end
   end

   assign req_ready   = rst ? w_ready : '0;
   assign ser_valid   = (state_q == S_SEND);
   assign ser_data    = (state_q == S_SEND) & shreg_q[PKT_W-1];
   assign grant_id    = grant_q;
   assign busy        = (state_q != S_IDLE);
   assign timeout_err = err_q;

endmodule
`default_nettype wire

// File: tb/tb_switch_ingress_arbiter.sv
`default_nettype none
// ============================================================================
// tb_switch_ingress_arbiter
//   Directed scenarios plus randomized traffic against a packet-level model.
//   Revision: 1.0
// ============================================================================
module tb_switch_ingress_arbiter;

   localparam int NUM_REQ  = 4;
   localparam int PKT_W    = 64;
   localparam int TMO      = 200;
   localparam int RAND_CYC = 20000;

   logic                     clk = 1'b0;
   logic                     rst;
   logic [NUM_REQ-1:0]       req_valid = '0;
   logic [NUM_REQ*PKT_W-1:0] req_data = '0;
   logic [NUM_REQ-1:0]       req_ready;
   logic                     ser_data, ser_valid;
   logic                     sw_valid_out = 1'b0;
   logic [2:0]               grant_id;
   logic                     busy, timeout_err;
   logic                     err_clr = 1'b0;

   switch_ingress_arbiter #(
      .NUM_REQ(NUM_REQ), .PKT_W(PKT_W), .TIMEOUT_CYC(TMO)
   ) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
      .req_ready(req_ready), .ser_data(ser_data), .ser_valid(ser_valid),
      .sw_valid_out(sw_valid_out), .grant_id(grant_id), .busy(busy),
      .timeout_err(timeout_err), .err_clr(err_clr)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: captures the serial stream and the accept vector
   logic [PKT_W-1:0]   cap = '0;
   int                 cap_cnt = 0;
   int                 rx_bits = 0;
   bit                 rx_done = 1'b0;
   logic [NUM_REQ-1:0] acc_vec = '0;

   initial forever begin
      @(negedge clk);
      acc_vec = req_ready;
      if (!rst) rx_bits = 0;
      else if (ser_valid) begin
         cap = {cap[PKT_W-2:0], ser_data};
         cap_cnt++;
         rx_bits++;
         if (rx_bits == PKT_W) begin
            rx_bits = 0;
            rx_done = 1'b1;
         end
      end
   end

   // Packet-level model: bits still to send, waiting-for-burst flag, wait cycles used
   int               m_left = 0;
   logic [PKT_W-1:0] m_pkt = '0;
   bit               m_wait = 1'b0, m_rose = 1'b0;
   int               m_wcnt = 0;
   int               m_gid = NUM_REQ - 1;
   bit               m_err = 1'b0;

   initial begin : p_cmp
      logic [NUM_REQ-1:0] e_ready;
      int                 g, c;
      bit                 idle, set;
      forever begin
         @(negedge clk);
         if (!rst) begin
            m_left = 0; m_wait = 0; m_rose = 0; m_wcnt = 0;
            m_gid  = NUM_REQ - 1; m_err = 0;
         end
         idle = (m_left == 0) && !m_wait;
         g = -1;
         if (idle && rst) begin
            for (int k = 1; k <= NUM_REQ; k++) begin
               c = (m_gid + k) % NUM_REQ;
               if (g < 0 && req_valid[c]) g = c;
            end
         end
         e_ready = '0;
         if (g >= 0) e_ready[g] = 1'b1;
         check("req_ready", req_ready, e_ready);
         check("ser_valid", ser_valid, m_left > 0);
         check("ser_data", ser_data, (m_left > 0) ? m_pkt[m_left-1] : 1'b0);
         check("busy", busy, !idle);
         check("grant_id", grant_id, m_gid);
         check("timeout_err", timeout_err, m_err);
         if (rst) begin
            set = 1'b0;
            if (g >= 0) begin
               m_gid  = g;
               m_pkt  = req_data[g*PKT_W +: PKT_W];
               m_left = PKT_W;
            end else if (m_left > 0) begin
               m_left--;
               if (m_left == 0) begin
                  m_wait = 1; m_rose = 0; m_wcnt = 0;
               end
            end else if (m_wait) begin
               if (m_rose && !sw_valid_out) m_wait = 0;
               else if (m_wcnt == TMO - 1) begin
                  m_wait = 0;
                  set    = 1'b1;
               end else begin
                  if (sw_valid_out) m_rose = 1;
                  m_wcnt++;
               end
            end
            if (err_clr)  m_err = 0;
            else if (set) m_err = 1;
         end
      end
   end

   task automatic wait_accept(output int g);
      int n = 0;
      g = -1;
      while (g < 0 && n < 500) begin
         @(negedge clk); #1;
         n++;
         for (int i = 0; i < NUM_REQ; i++) if (req_ready[i] && g < 0) g = i;
      end
      if (g < 0) check("accept_timeout", n, 0);
      @(posedge clk); #1;
   endtask

   task automatic wait_bits(input int n);
      int k = 0;
      while (cap_cnt < n && k < 400) begin
         @(negedge clk); #1;
         k++;
      end
      if (cap_cnt < n) check("bits_timeout", cap_cnt, n);
   endtask

   task automatic burst(input int dly, input int len);
      repeat (dly) @(posedge clk);
      #1 sw_valid_out = 1'b1;
      repeat (len) @(posedge clk);
      #1 sw_valid_out = 1'b0;
   endtask

   task automatic do_reset();
      @(posedge clk); #1 rst = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
   endtask

   int g, n;
   int exp_rr[5] = '{0, 1, 2, 3, 0};
   int sw_dly = 0, sw_len = 0;

   initial begin
      rst = 1'b1;
      #1 rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_req_ready", req_ready, 0);
      check("rst_ser_valid", ser_valid, 0);
      check("rst_ser_data", ser_data, 0);
      check("rst_grant_id", grant_id, 3);
      check("rst_busy", busy, 0);
      check("rst_timeout_err", timeout_err, 0);
      @(posedge clk); #1 rst = 1'b1;

      // Single packet
      req_data[0 +: PKT_W] = 64'hDEAD_BEEF_0123_4567;
      req_valid = 4'b0001;
      cap_cnt = 0;
      wait_accept(g);
      check("t1_grant", g, 0);
      req_valid = '0;
      wait_bits(PKT_W);
      check("t1_bits", cap, 64'hDEAD_BEEF_0123_4567);
      burst(2, 64);
      @(negedge clk); #1 check("t1_busy_fall_cycle", busy, 1);
      @(negedge clk); #1 check("t1_busy_idle", busy, 0);

      // Round robin with all requesters held
      do_reset();
      for (int i = 0; i < NUM_REQ; i++) req_data[i*PKT_W +: PKT_W] = {$urandom, $urandom};
      req_valid = 4'b1111;
      for (int k = 0; k < 5; k++) begin
         cap_cnt = 0;
         wait_accept(g);
         check("rr_grant", g, exp_rr[k]);
         if (k == 4) req_valid = '0;
         wait_bits(PKT_W);
         burst(1, 64);
      end

      // Skip and wrap
      req_valid = 4'b0100;
      cap_cnt = 0;
      wait_accept(g);
      check("skip_grant2", g, 2);
      req_valid = 4'b0011;
      wait_bits(PKT_W);
      burst(1, 10);
      cap_cnt = 0;
      wait_accept(g);
      check("wrap_grant0", g, 0);
      wait_bits(PKT_W);
      burst(0, 64);
      cap_cnt = 0;
      wait_accept(g);
      check("wrap_grant1", g, 1);
      req_valid = '0;
      wait_bits(PKT_W);
      burst(1, 64);

      // Timeout with no egress burst
      req_valid = 4'b0001;
      cap_cnt = 0;
      wait_accept(g);
      req_valid = '0;
      wait_bits(PKT_W);
      n = 0;
      while (!timeout_err && n < 3 * TMO) begin
         @(negedge clk); #1;
         n++;
      end
      check("tmo_latency", n, TMO + 1);
      check("tmo_busy", busy, 0);
      @(posedge clk); #1 err_clr = 1'b1;
      @(posedge clk); #1 err_clr = 1'b0;
      check("tmo_cleared", timeout_err, 0);

      // Clear arriving on the same edge as the timeout
      req_valid = 4'b0001;
      cap_cnt = 0;
      wait_accept(g);
      req_valid = '0;
      wait_bits(PKT_W);
      repeat (TMO) @(posedge clk);
      #1 err_clr = 1'b1;
      @(posedge clk); #1 err_clr = 1'b0;
      check("tmo_clr_wins", timeout_err, 0);
      check("tmo_clr_busy", busy, 0);

      // Reset in the middle of a packet
      req_data[0 +: PKT_W] = 64'h0123_4567_89AB_CDEF;
      req_valid = 4'b0001;
      cap_cnt = 0;
      wait_accept(g);
      wait_bits(30);
      @(posedge clk); #1 rst = 1'b0;
      #1;
      check("mid_rst_ser_valid", ser_valid, 0);
      check("mid_rst_busy", busy, 0);
      check("mid_rst_grant", grant_id, 3);
      @(posedge clk); #1 rst = 1'b1;
      cap_cnt = 0;
      wait_accept(g);
      check("mid_rst_regrant", g, 0);
      req_valid = '0;
      wait_bits(PKT_W);
      check("mid_rst_bits", cap, 64'h0123_4567_89AB_CDEF);
      check("mid_rst_count", cap_cnt, PKT_W);
      burst(3, 40);

      // Randomized traffic with an emulated switch
      repeat (4) @(posedge clk);
      rx_done = 1'b0;
      for (int cyc = 0; cyc < RAND_CYC; cyc++) begin
         @(posedge clk); #1;
         for (int i = 0; i < NUM_REQ; i++) begin
            if (acc_vec[i]) begin
               req_data[i*PKT_W +: PKT_W] = {$urandom, $urandom};
               req_valid[i] = ($urandom % 2) == 1;
            end else if (!req_valid[i]) begin
               if ($urandom % 8 == 0) begin
                  req_valid[i] = 1'b1;
                  req_data[i*PKT_W +: PKT_W] = {$urandom, $urandom};
               end
            end else if ($urandom % 64 == 0) begin
               req_valid[i] = 1'b0;
            end
         end
         err_clr = ($urandom % 40 == 0);
         if (rx_done) begin
            rx_done = 1'b0;
            if ($urandom % 12 == 0) begin
               sw_dly = 0;
               sw_len = 0;
            end else begin
               sw_dly = $urandom % 25;
               sw_len = 1 + $urandom % 210;
            end
         end
         if (rx_bits > 0) sw_valid_out = ($urandom % 6 == 0);
         else if (sw_dly > 0) begin
            sw_valid_out = 1'b0;
            sw_dly--;
         end else if (sw_len > 0) begin
            sw_valid_out = 1'b1;
            sw_len--;
         end else sw_valid_out = 1'b0;
      end
      req_valid = '0;
      sw_valid_out = 1'b0;
      err_clr = 1'b0;
      repeat (300) @(posedge clk);
      #1;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
